// File: rtl/channel_decoder.sv
// Receive-side codeword checker: validates {data[6:0], popcount checksum[2:0]},
// queues good payloads in a small FIFO, tracks statistics and faults on error bursts.
module channel_decoder #(
  parameter int DEPTH     = 4,
  parameter int ERR_LIMIT = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [9:0]       in_word,
  output logic             in_ready,
  output logic             out_valid,
  output logic [6:0]       out_data,
  input  logic             out_ready,
  input  logic             clear_fault,
  output logic             fault,
  output logic             err_pulse,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  state_t           r_state;
  logic [6:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [EW-1:0]    r_consec;
  logic [6:0]       r_out_data;
  logic             r_fault;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [2:0]       w_popcnt;
  logic             w_good;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_bad;
  logic             w_pop;
  logic [6:0]       w_payload;
  logic [AW-1:0]    w_rd_ptr_inc;
  logic [6:0]       w_head_nxt;

  assign w_payload    = in_word[9:3];
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign in_ready     = (r_state == S_RUN) && !w_full;
  assign w_accept     = in_valid && in_ready;
  assign w_push       = w_accept && w_good;
  assign w_bad        = w_accept && !w_good;
  assign w_pop        = !w_empty && out_ready;
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

  always_comb begin
    w_popcnt = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      w_popcnt = w_popcnt + 3'(w_payload[i]);
    end
  end

  assign w_good = (in_word[2:0] == w_popcnt);

  // out_data is a register tracking the post-edge FIFO head so it stays
  // stable under backpressure and holds its last value once drained.
  always_comb begin
    w_head_nxt = r_out_data;
    if (w_pop) begin
      if (r_count > CW'(1)) begin
        w_head_nxt = r_mem[w_rd_ptr_inc];
      end else if (w_push) begin
        w_head_nxt = w_payload;
      end
    end else if (w_empty && w_push) begin
      w_head_nxt = w_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_data <= '0;
    end else begin
      r_out_data <= w_head_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good_cnt  <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_bad;
      if (w_push && r_good_cnt != '1) begin
        r_good_cnt <= r_good_cnt + CNT_W'(1);
      end
      if (w_bad && r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_fault  <= 1'b0;
      r_consec <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_push) begin
            r_consec <= '0;
          end else if (w_bad) begin
            if (r_consec != EW'(ERR_LIMIT)) begin
              r_consec <= r_consec + EW'(1);
            end
            if (r_consec == EW'(ERR_LIMIT - 1)) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          if (clear_fault) begin
            r_state  <= S_RUN;
            r_fault  <= 1'b0;
            r_consec <= '0;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = r_out_data;
  assign fault     = r_fault;
  assign err_pulse = r_err_pulse;
  assign good_cnt  = r_good_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_channel_decoder.sv
// Directed self-checking bench for channel_decoder (DEPTH=4, ERR_LIMIT=3).
module tb_channel_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [9:0]  in_word;
  logic        in_ready;
  logic        out_valid;
  logic [6:0]  out_data;
  logic        out_ready;
  logic        clear_fault;
  logic        fault;
  logic        err_pulse;
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          q[$];

  channel_decoder #(.DEPTH(4), .ERR_LIMIT(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .clear_fault(clear_fault), .fault(fault),
    .err_pulse(err_pulse), .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic [6:0] d);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < 7; i++) p = p + 3'(d[i]);
    return {d, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] w);
    in_valid = 1'b1;
    in_word  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; clear_fault = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fault", fault, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_good_cnt", good_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // good word
    send(10'h2CC);
    chk("good_out_valid", out_valid, 1);
    chk("good_out_data", out_data, 7'h59);
    chk("good_good_cnt", good_cnt, 1);
    chk("good_err_cnt", err_cnt, 0);
    chk("good_err_pulse", err_pulse, 0);
    pop1();
    chk("good_drained", out_valid, 0);

    // bad word, then two good words
    send(10'h2CD);
    chk("bad_out_valid", out_valid, 0);
    chk("bad_err_pulse", err_pulse, 1);
    chk("bad_err_cnt", err_cnt, 1);
    tick();
    chk("bad_pulse_one_cycle", err_pulse, 0);
    send(10'h3FF);
    send(10'h000);
    chk("order_head0", out_data, 7'h7F);
    pop1();
    chk("order_valid1", out_valid, 1);
    chk("order_head1", out_data, 7'h00);
    pop1();
    chk("order_empty", out_valid, 0);
    chk("order_good_cnt", good_cnt, 3);

    // full FIFO, no bypass
    for (int k = 1; k <= 4; k++) begin
      chk("full_ready_pre", in_ready, 1);
      send(mk(7'(k)));
    end
    in_valid = 1'b1; in_word = mk(7'd5);
    chk("full_ready_low", in_ready, 0);
    tick();
    chk("full_held", in_ready, 0);
    chk("full_head", out_data, 7'd1);
    out_ready = 1'b1;
    chk("full_no_bypass", in_ready, 0);
    tick();
    out_ready = 1'b0;
    chk("full_ready_after_pop", in_ready, 1);
    chk("full_head_after_pop", out_data, 7'd2);
    tick();
    in_valid = 1'b0;
    chk("full_again", in_ready, 0);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("full_drain_valid", out_valid, 1);
      chk("full_drain_data", out_data, 7'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("full_drained", out_valid, 0);
    chk("full_good_cnt", good_cnt, 8);

    // streaming with two entries resident
    send(mk(7'd10)); send(mk(7'd11));
    q.push_back(10); q.push_back(11);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_word = mk(7'(12 + c)); out_ready = 1'b1;
      chk("stream_data", out_data, 7'(q[0]));
      chk("stream_valid", out_valid, 1);
      chk("stream_ready", in_ready, 1);
      tick();
      void'(q.pop_front());
      q.push_back(12 + c);
    end
    in_valid = 1'b0;
    while (q.size() > 0) begin
      chk("stream_tail", out_data, 7'(q[0]));
      tick();
      void'(q.pop_front());
    end
    out_ready = 1'b0;
    chk("stream_empty", out_valid, 0);
    chk("stream_good_cnt", good_cnt, 30);

    // fault entry, drain while faulted, clear
    send(mk(7'h33));
    send(10'h2CD); send(10'h2CD);
    chk("fault_not_yet", fault, 0);
    send(10'h2CD);
    chk("fault_set", fault, 1);
    chk("fault_in_ready", in_ready, 0);
    chk("fault_err_cnt", err_cnt, 4);
    chk("fault_head", out_data, 7'h33);
    in_valid = 1'b1; in_word = mk(7'h44); out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fault_drained", out_valid, 0);
    chk("fault_good_hold", good_cnt, 31);
    chk("fault_hold", fault, 1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clear_fault", fault, 0);
    chk("clear_in_ready", in_ready, 1);
    send(mk(7'h50));
    chk("clear_accept", out_data, 7'h50);
    chk("clear_good_cnt", good_cnt, 32);
    pop1();

    // two bad, one good, two bad: no fault
    send(10'h2CD); send(10'h2CD); send(mk(7'h51)); send(10'h2CD); send(10'h2CD);
    chk("mixed_no_fault", fault, 0);
    chk("mixed_err_cnt", err_cnt, 8);
    pop1();
    send(10'h2CD);
    chk("mixed_third_bad", fault, 1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;

    // fault with 3 entries, then async reset
    send(mk(7'h41)); send(mk(7'h42)); send(mk(7'h43));
    send(10'h2CD); send(10'h2CD); send(10'h2CD);
    chk("pre_rst_fault", fault, 1);
    chk("pre_rst_head", out_data, 7'h41);
    chk("pre_rst_good", good_cnt, 36);
    chk("pre_rst_err", err_cnt, 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_fault", fault, 0);
    chk("arst_err_pulse", err_pulse, 0);
    chk("arst_good_cnt", good_cnt, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/channel_decoder.md
Name: channel_decoder

Overview:
- Receive stage directly downstream of the channel in the Simple Encoding chain; consumes the 10-bit codewords the channel delivers.
- Codeword format: data = word[9:3] (7 bits), checksum = word[2:0]. Checksum = popcount(data) mod 8.
- Verifies each codeword, buffers good payloads in a small FIFO for the sink, drops bad ones, keeps good/error statistics.
- Enters a FAULT state after too many consecutive corrupted words.

Parameters:
- DEPTH, 4, FIFO entries of 7-bit payload (power of two, >= 2)
- ERR_LIMIT, 3, consecutive bad words that trigger FAULT (>= 1)
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  codeword valid from channel
- in_word  in  10  codeword {data[6:0], checksum[2:0]}
- in_ready  out  1  decoder accepts codeword this cycle
- out_valid  out  1  FIFO head valid
- out_data  out  7  FIFO head payload
- out_ready  in  1  sink pops head
- clear_fault  in  1  leaves FAULT state
- fault  out  1  high in FAULT state
- err_pulse  out  1  one-cycle pulse after a bad word is accepted
- good_cnt  out  CNT_W  good words accepted, saturating
- err_cnt  out  CNT_W  bad words accepted, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: FIFO empty, out_valid=0, out_data=0, state=RUN, fault=0, err_pulse=0, good_cnt=0, err_cnt=0, consecutive-error counter consec=0.
- Accept: a word is accepted on a rising edge with in_valid && in_ready.
  - in_ready = (state==RUN) && !full. It never depends on in_word.
  - No bypass when full: a simultaneous pop while full does not raise in_ready in the same cycle.
- Check: combinational on in_word at acceptance. good = (in_word[2:0] == popcount(in_word[9:3])[2:0]).
- Good word:
  - Payload is pushed into the FIFO on the accepting edge. out_valid rises the next cycle if the FIFO was empty (latency 1).
  - good_cnt += 1, saturating at all-ones. consec cleared to 0.
- Bad word:
  - Handshake completes, but the payload is discarded and never pushed.
  - err_cnt += 1, saturating. consec += 1, saturating at ERR_LIMIT.
  - err_pulse = 1 for exactly the next cycle.
- FIFO:
  - out_valid = !empty. out_data = head entry, registered/stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop (non-full): occupancy unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - out_data holds its last value when empty (don't-care for the checker).
- State machine (RUN, FAULT):
  - RUN -> FAULT on the edge where a bad word makes consec reach ERR_LIMIT. fault=1 from the next cycle. in_ready=0 from the next cycle.
  - FAULT: no words accepted. The FIFO keeps draining to the sink normally. Counters hold.
  - FAULT -> RUN on the edge with clear_fault=1. consec cleared to 0 on that edge. in_ready is re-evaluated from the next cycle.
  - clear_fault in RUN is ignored. Statistics counters are not cleared by clear_fault.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). FIFO contents are lost. The sink must discard any partially observed transfer.

Test Plan:
- Good word: in_word=10'h2CC (data 7'b1011001, checksum 3'b100) accepted -> out_valid=1 next cycle, out_data=7'h59, good_cnt=1, err_cnt=0, err_pulse=0.
- Bad word: in_word=10'h2CD -> no out_valid, err_pulse=1 for one cycle, err_cnt=1. Then 10'h3FF and 10'h000 -> out_data 7'h7F then 7'h00, in order, consec=0.
- Full FIFO: out_ready=0, in_valid=1 with 5 good words, DEPTH=4 -> in_ready drops after 4 accepts, the 5th is held by the source. Pop one -> 5th accepted the following cycle. Drain order matches input order.
- Simultaneous push/pop with 2 entries -> occupancy stays 2, no word lost or duplicated over 20 cycles of streaming.
- FAULT: 3 consecutive bad words (10'h2CD) -> fault=1, in_ready=0. FIFO still drains. clear_fault pulse -> fault=0, next good word accepted. err_cnt=3. Two bad, one good, two bad -> no FAULT.
- Async reset asserted with 3 entries and fault=1 -> all outputs reach reset values immediately, without waiting for a clock edge.
